// File: rtl/fmap_stream_reader.sv
// fmap_stream_reader: walks the per-channel feature-map buffers after a layer
// completes and streams flattened activations over a valid/ready port.
module fmap_stream_reader #(
  parameter int CH = 8,
  parameter int H  = 14,
  parameter int W  = 14,
  parameter int AW = 10,
  parameter int DW = 8,
  parameter int IW = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 rd_en,
  output logic [2:0]           rd_ch,
  output logic [AW-1:0]        rd_addr,
  input  logic signed [DW-1:0] rd_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_data,
  output logic [IW-1:0]        out_index,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
);

  localparam int NPIX = H * W;
  localparam int NTOT = CH * NPIX;
  localparam int CW   = $clog2(W);
  localparam int RW   = $clog2(H);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          done_q, done_d;
  logic [2:0]    ch_q;
  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;
  logic [AW-1:0] addr_q;
  logic [IW-1:0] idx_q;

  logic          infl_q;
  logic [IW-1:0] tag_q;
  logic          tlast_q;

  logic signed [DW-1:0] dat_q [2];
  logic [IW-1:0]        fidx_q [2];
  logic                 flast_q [2];
  logic                 rp_q, wp_q;
  logic [1:0]           cnt_q;

  logic pop, push, room, last_issue;
  logic col_wrap, row_wrap, ch_wrap;

  assign pop  = out_valid & out_ready;
  assign push = infl_q;

  // slots already committed (held + returning) must leave space for one more
  assign room = ({1'b0, cnt_q} + {2'b00, infl_q})
              < (3'd2 + {2'b00, pop});

  assign rd_en      = (state_q == S_RUN) & room;
  assign last_issue = rd_en & (idx_q == IW'(NTOT - 1));

  assign col_wrap = (col_q == CW'(W - 1));
  assign row_wrap = (row_q == RW'(H - 1));
  assign ch_wrap  = (ch_q == 3'(CH - 1));

  assign rd_ch     = ch_q;
  assign rd_addr   = addr_q;
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = dat_q[rp_q];
  assign out_index = fidx_q[rp_q];
  assign out_last  = flast_q[rp_q];
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;

  // next-state: start is only honoured when idle and not in the done cycle
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (start && !done_q) state_d = S_RUN;
      end
      (state_q == S_RUN): begin
        if (last_issue) state_d = S_DRAIN;
      end
      (state_q == S_DRAIN): begin
        if (pop && out_last) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state register and one-cycle done pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // issue counters: col -> row -> ch, all wrap to zero after the last read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch_q   <= '0;
      row_q  <= '0;
      col_q  <= '0;
      addr_q <= '0;
      idx_q  <= '0;
    end else if (rd_en) begin
      idx_q <= last_issue ? '0 : idx_q + 1'b1;
      if (col_wrap) begin
        col_q <= '0;
        if (row_wrap) begin
          row_q  <= '0;
          addr_q <= '0;
          ch_q   <= ch_wrap ? 3'd0 : ch_q + 3'd1;
        end else begin
          row_q  <= row_q + 1'b1;
          addr_q <= addr_q + 1'b1;
        end
      end else begin
        col_q  <= col_q + 1'b1;
        addr_q <= addr_q + 1'b1;
      end
    end
  end

  // tag travelling alongside the read so returning data knows its index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      infl_q  <= 1'b0;
      tag_q   <= '0;
      tlast_q <= 1'b0;
    end else begin
      infl_q  <= rd_en;
      tag_q   <= idx_q;
      tlast_q <= last_issue;
    end
  end

  // two-entry output fifo; head entry drives the stream port directly
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        dat_q[i]   <= '0;
        fidx_q[i]  <= '0;
        flast_q[i] <= 1'b0;
      end
      rp_q  <= 1'b0;
      wp_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push) begin
        dat_q[wp_q]   <= rd_data;
        fidx_q[wp_q]  <= tag_q;
        flast_q[wp_q] <= tlast_q;
        wp_q          <= ~wp_q;
      end
      if (pop) rp_q <= ~rp_q;
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_fmap_stream_reader.sv
// tb_fmap_stream_reader: scoreboard bench for fmap_stream_reader with a
// synchronous buffer model, backpressure, start collisions and mid-run reset.
module tb_fmap_stream_reader;

  localparam int NTOT = 1568;
  localparam int NPIX = 196;
  localparam int LIM  = 20000;

  typedef struct packed {
    logic [7:0]  d;
    logic [10:0] i;
    logic        l;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        rd_en;
  logic [2:0]  rd_ch;
  logic [9:0]  rd_addr;
  logic [7:0]  rd_data = 8'd0;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [10:0] out_index;
  logic        out_last;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mode = 1;
  int stuck_cnt = 0;
  bit stuck_done = 1;
  bit stuck_seen = 0;
  bit wrap_ok = 0;
  exp_t exp_q[$];

  fmap_stream_reader dut (
    .clk(clk), .rst(rst), .start(start),
    .rd_en(rd_en), .rd_ch(rd_ch), .rd_addr(rd_addr),
    .rd_data(rd_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] mval(int c, int a);
    return 8'(c * 16 + (a & 15));
  endfunction

  always @(posedge clk)
    if (rd_en) rd_data <= mval(int'(rd_ch), int'(rd_addr));

  always @(posedge clk) begin
    #1;
    if (mode == 0) out_ready = 1'b1;
    else if (stuck_cnt > 0) begin
      out_ready = 1'b0;
      stuck_cnt--;
    end else if (!stuck_done && out_valid && out_index == 11'd300) begin
      stuck_done = 1;
      stuck_seen = 1;
      stuck_cnt  = 19;
      out_ready  = 1'b0;
    end else out_ready = 1'($urandom_range(0, 1));
  end

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic load_exp();
    exp_q.delete();
    for (int i = 0; i < NTOT; i++) begin
      exp_t e;
      e.d = mval(i / NPIX, i % NPIX);
      e.i = 11'(i);
      e.l = (i == NTOT - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_rd_en"}, int'(rd_en), 0);
    chk({tag, "_rd_ch"}, int'(rd_ch), 0);
    chk({tag, "_rd_addr"}, int'(rd_addr), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_data"}, int'(out_data), 0);
    chk({tag, "_out_index"}, int'(out_index), 0);
    chk({tag, "_out_last"}, int'(out_last), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  // monitor: scoreboard pops, stall stability, issue bound, channel wrap
  int   issued, popped;
  bit   pstall, prd;
  logic [7:0]  pd;
  logic [10:0] pi;
  logic        pl;
  logic [2:0]  pch;
  logic [9:0]  paddr;

  always @(negedge clk) begin
    if (!rst) begin
      issued = 0;
      popped = 0;
      pstall = 0;
      prd    = 0;
    end else begin
      if (pstall) begin
        checks++;
        if (!out_valid || out_data != pd || out_index != pi
            || out_last != pl) begin
          errors++;
          $display("FAIL stall_hold act=%0d/%0d/%0d exp=%0d/%0d/%0d",
                   out_valid, out_index, out_data, 1, pi, pd);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected act=idx%0d exp=none", out_index);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (out_data != e.d || out_index != e.i || out_last != e.l) begin
            errors++;
            $display("FAIL sb_beat act=%0d/%0d/%0d exp=%0d/%0d/%0d",
                     out_index, out_data, out_last, e.i, e.d, e.l);
          end
        end
      end
      if (rd_en) begin
        checks++;
        if ((issued - popped) + 1 - int'(out_valid && out_ready) > 2) begin
          errors++;
          $display("FAIL issue_bound act=%0d exp<=2",
                   (issued - popped) + 1 - int'(out_valid && out_ready));
        end
        if (rd_ch == 3'd1 && rd_addr == 10'd0 && prd
            && pch == 3'd0 && paddr == 10'd195)
          wrap_ok = 1;
      end
      issued += int'(rd_en);
      popped += int'(out_valid && out_ready);
      pstall = out_valid && !out_ready;
      pd = out_data; pi = out_index; pl = out_last;
      prd = rd_en; pch = rd_ch; paddr = rd_addr;
    end
  end

  task automatic full_run(string tag);
    int t0, n;
    mode = 0;
    load_exp();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    t0 = cyc;
    chk({tag, "_busy_k"}, int'(busy), 1);
    chk({tag, "_rden_k"}, int'(rd_en), 1);
    chk({tag, "_addr_k"}, int'(rd_addr), 0);
    n = 0;
    while (!done && n < LIM) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIM) chk({tag, "_timeout"}, n, 0);
    chk({tag, "_done_lat"}, cyc - t0, 1570);
    chk({tag, "_sb_empty"}, exp_q.size(), 0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, int'(done), 0);
    chk({tag, "_busy_end"}, int'(busy), 0);
  endtask

  initial begin
    int n;
    bit s700;
    rst = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
    end
    chk_reset_vals("rst");
    @(negedge clk) begin
      start = 1'b0;
      rst = 1'b1;
    end
    repeat (4) @(negedge clk);
    chk("idle_rd_en", int'(rd_en), 0);
    chk("idle_busy", int'(busy), 0);

    full_run("run1");
    chk("wrap_seen", int'(wrap_ok), 1);

    mode = 1;
    stuck_done = 0;
    s700 = 0;
    load_exp();
    @(negedge clk) start = 1'b1;
    n = 0;
    while (n < LIM) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (done) break;
      if (!s700 && out_valid && out_index == 11'd700) begin
        start = 1'b1;
        s700 = 1;
      end
    end
    if (n >= LIM) chk("bp_timeout", n, 0);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (5) @(negedge clk);
    chk("bp_busy_after", int'(busy), 0);
    chk("bp_valid_after", int'(out_valid), 0);
    chk("bp_sb_empty", exp_q.size(), 0);
    chk("bp_stuck_seen", int'(stuck_seen), 1);
    chk("bp_s700_seen", int'(s700), 1);

    mode = 0;
    load_exp();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0;
    while (!(out_valid && out_index == 11'd500) && n < LIM) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIM) chk("mid_timeout", n, 0);
    rst = 1'b0;
    #1;
    chk_reset_vals("mid");
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_idle_valid", int'(out_valid), 0);

    full_run("run4");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fmap_stream_reader.md
# fmap_stream_reader

Read-side engine for the per-channel feature-map buffers that a convolution layer fills through its store/address/result write port. After a layer signals completion, the block walks every channel buffer in channel-major, row-major order. It issues synchronous reads and streams the flattened activations to the next stage, the fully-connected layer, over a valid/ready handshake. It is the consumer end of the layer-output memory, and it sits between the layer-2 buffers and FC input.

## Interface
- CH, 8, number of output-channel buffers to read
- H, 14, rows per pooled channel map
- W, 14, columns per pooled channel map
- AW, 10, buffer address width
- DW, 8, activation width (signed)
- IW, 11, flattened-index width; must hold CH*H*W-1
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: begin streaming (issued after final pool_done)
- rd_en  out  1  read strobe to selected channel buffer
- rd_ch  out  3  channel buffer select
- rd_addr  out  AW  word address inside channel buffer, r*W+col
- rd_data  in  DW  signed read data, valid one cycle after rd_en
- out_valid  out  1  out_data/out_index/out_last valid
- out_ready  in  1  downstream accepts when high with out_valid
- out_data  out  DW  activation, unmodified
- out_index  out  IW  flattened index c*H*W + r*W + col
- out_last  out  1  high with element CH*H*W-1
- busy  out  1  streaming in progress
- done  out  1  one-cycle pulse after last handshake

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE: all counters zero. When start=1, go to RUN and set busy.
- RUN: issue counters (ch, row, col) advance col→row→ch with wrap at W, H, CH. A read is issued (rd_en=1 with the current rd_ch/rd_addr) when count + inflight − pop < 2.
  - count: occupancy of a 2-entry output buffer.
  - inflight: rd_en registered last cycle.
  - pop: out_valid & out_ready.
- When the issue of index CH*H*W-1 occurs, go to DRAIN. No further rd_en is issued.
- Return data is pushed into the 2-entry FIFO, tagged with its index; out_last is set for the final index.
- DRAIN: when the last handshake (out_last & out_valid & out_ready) happens, go to IDLE. busy drops and done pulses high for exactly one cycle.
- start is ignored while busy=1. A start arriving in the same cycle done is high is also ignored.
- While out_valid=1 and out_ready=0, out_data, out_index and out_last must hold stable.
- No element is dropped or duplicated under any out_ready pattern.
- Reset, whether asserted in IDLE or mid-stream:
  - FSM returns to IDLE and the FIFO is flushed.
  - Any in-flight read is discarded.
  - The next start restarts from index 0.

## Timing
- Reset values: rd_en=0, rd_ch=0, rd_addr=0, out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, done=0.
- start sampled at edge k.
  - busy=1 and first rd_en=1 (addr 0, ch 0) after edge k.
  - rd_data is captured at edge k+2; out_valid=1 after edge k+2.
- With out_ready held high, throughput is 1 element/cycle with no bubbles, including across channel wrap.
  - Start-to-done: last handshake at cycle k+2+CH*H*W-1, done high in the following cycle.
  - Defaults: done is high after edge k+1570.
- Channel wrap: rd_addr goes H*W-1 → 0 in the same cycle rd_ch increments.
- Read latency from the buffer is exactly 1 cycle. rd_addr/rd_ch are stable in the cycle rd_en is high.

## Test plan
- Reset: hold rst=0 for 3 cycles with random inputs → every output at its reset value; release and stay idle → rd_en=0, busy=0.
- Full stream, out_ready=1, memory model returns (ch*16 + addr[3:0]):
  - 1568 consecutive beats; out_index runs 0..1567 with data matching the model.
  - out_last only at 1567; done pulses after edge k+1570.
- Backpressure: out_ready pseudo-random at 50%, then stuck low for 20 cycles at index 300:
  - outputs stay stable while stalled.
  - Scoreboard sees all 1568 elements in order, none duplicated.
  - rd_en never issues while count+inflight would exceed 2.
- Channel wrap: observe the index 195→196 issue → rd_ch 0→1 and rd_addr 195→0 on consecutive rd_en cycles; out_data continuity holds at the wrap.
- Start collisions: start pulsed at index 700 and again in the done cycle → both ignored; a later start in IDLE restarts from index 0.
- Reset mid-stream at out_index 500 with a read in flight → outputs go to reset values immediately. The next start streams from index 0 with no stale data emitted.
